// File: rtl/operand_field_encoder_seq_pkg.sv
// Shared types, widths and word layout for the operand field encoder.
package operand_field_encoder_seq_pkg;

  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned OPTYPE_W   = 3;
  localparam int unsigned OPND_W     = 16;
  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned MODE_W     = FIELD_W - REG_ADDR_W;
  localparam int unsigned INSTR_W    = OPCODE_W + OPTYPE_W + 3 * FIELD_W;

  // Instruction word bit positions
  localparam int unsigned F3_LSB     = 0;
  localparam int unsigned F2_LSB     = FIELD_W;
  localparam int unsigned F1_LSB     = 2 * FIELD_W;
  localparam int unsigned OPTYPE_LSB = 3 * FIELD_W;
  localparam int unsigned OPC_MSB    = INSTR_W - 1;

  // Legal operand ranges, held at operand width so compares stay same-width
  localparam logic signed [OPND_W-1:0] IMM_MIN = OPND_W'(-128);
  localparam logic signed [OPND_W-1:0] IMM_MAX = OPND_W'(127);
  localparam logic signed [OPND_W-1:0] REG_MAX = OPND_W'(63);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP1  = 3'd1,
    OP2  = 3'd2,
    OP3  = 3'd3,
    OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/operand_field_encoder_seq_pack.sv
// Packs one signed operand into an 8-bit field and flags out-of-range values.
module operand_field_pack
  import operand_field_encoder_seq_pkg::*;
(
  input  logic signed [OPND_W-1:0]  i_value,
  input  logic        [MODE_W-1:0]  i_mode,
  input  logic                      i_is_reg,
  output logic        [FIELD_W-1:0] o_field_c,
  output logic                      o_err_c
);

  // Truncate to field width; the error flag reports loss, no saturation
  always_comb begin
    o_field_c = i_value[FIELD_W-1:0];
    o_err_c   = 1'b0;
    if (i_is_reg) begin
      o_field_c = {i_mode, i_value[REG_ADDR_W-1:0]};
      o_err_c   = i_value[OPND_W-1] || (i_value > REG_MAX);
    end else begin
      o_err_c   = (i_value < IMM_MIN) || (i_value > IMM_MAX);
    end
  end

endmodule

// File: rtl/operand_field_encoder_seq.sv
// Collects a header and three operands, packs them into one instruction word.
module operand_field_encoder_seq
  import operand_field_encoder_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hdr_valid,
  output logic                      hdr_ready,
  input  logic        [OPCODE_W-1:0] hdr_opcode,
  input  logic        [OPTYPE_W-1:0] hdr_optype,
  input  logic                      opnd_valid,
  output logic                      opnd_ready,
  input  logic signed [OPND_W-1:0]  opnd_value,
  input  logic        [MODE_W-1:0]  opnd_mode,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic        [INSTR_W-1:0] instr_word,
  output logic                      instr_err,
  output logic        [2:0]         err_mask
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_armed;
  logic [OPCODE_W-1:0]  r_opcode;
  logic [OPTYPE_W-1:0]  r_optype;
  logic [FIELD_W-1:0]   r_f1;
  logic [FIELD_W-1:0]   r_f2;
  logic [FIELD_W-1:0]   r_f3;
  logic [2:0]           r_err;

  logic                 w_hdr_ready;
  logic                 w_opnd_ready;
  logic                 w_instr_valid;
  logic                 w_is_reg;
  logic                 w_hdr_acc;
  logic                 w_opnd_acc;
  logic [FIELD_W-1:0]   w_field;
  logic                 w_err;

  // State register; r_armed keeps hdr_ready low while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_hdr_ready   = 1'b0;
    w_opnd_ready  = 1'b0;
    w_instr_valid = 1'b0;
    w_is_reg      = 1'b0;
    case (r_state)
      IDLE: begin
        w_hdr_ready = r_armed;
        if (hdr_valid && r_armed) w_state_nxt = OP1;
      end
      OP1: begin
        w_opnd_ready = 1'b1;
        w_is_reg     = r_optype[2];
        if (opnd_valid) w_state_nxt = OP2;
      end
      OP2: begin
        w_opnd_ready = 1'b1;
        w_is_reg     = r_optype[1];
        if (opnd_valid) w_state_nxt = OP3;
      end
      OP3: begin
        w_opnd_ready = 1'b1;
        w_is_reg     = r_optype[0];
        if (opnd_valid) w_state_nxt = OUT;
      end
      OUT: begin
        w_instr_valid = 1'b1;
        w_hdr_ready   = instr_ready;
        if (instr_ready) w_state_nxt = hdr_valid ? OP1 : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hdr_acc  = hdr_valid  & w_hdr_ready;
  assign w_opnd_acc = opnd_valid & w_opnd_ready;

  operand_field_pack u_pack (
    .i_value   (opnd_value),
    .i_mode    (opnd_mode),
    .i_is_reg  (w_is_reg),
    .o_field_c (w_field),
    .o_err_c   (w_err)
  );

  // Header/field capture; a new header wipes any previous fields and errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_optype <= '0;
      r_f1     <= '0;
      r_f2     <= '0;
      r_f3     <= '0;
      r_err    <= '0;
    end else if (w_hdr_acc) begin
      r_opcode <= hdr_opcode;
      r_optype <= hdr_optype;
      r_f1     <= '0;
      r_f2     <= '0;
      r_f3     <= '0;
      r_err    <= '0;
    end else if (w_opnd_acc) begin
      case (r_state)
        OP1: begin
          r_f1     <= w_field;
          r_err[2] <= w_err;
        end
        OP2: begin
          r_f2     <= w_field;
          r_err[1] <= w_err;
        end
        OP3: begin
          r_f3     <= w_field;
          r_err[0] <= w_err;
        end
        default: ;
      endcase
    end
  end

  assign hdr_ready   = w_hdr_ready;
  assign opnd_ready  = w_opnd_ready;
  assign instr_valid = w_instr_valid;
  assign instr_word  = {r_opcode, r_optype, r_f1, r_f2, r_f3};
  assign err_mask    = r_err;
  assign instr_err   = |r_err;

endmodule

// File: tb/tb_operand_field_encoder_seq.sv
// Directed bench for operand_field_encoder_seq: vector table plus corner sequences.
module tb_operand_field_encoder_seq;
  import operand_field_encoder_seq_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                hdr_valid = 1'b0;
  logic                hdr_ready;
  logic [OPCODE_W-1:0] hdr_opcode = '0;
  logic [OPTYPE_W-1:0] hdr_optype = '0;
  logic                opnd_valid = 1'b0;
  logic                opnd_ready;
  logic [OPND_W-1:0]   opnd_value = '0;
  logic [MODE_W-1:0]   opnd_mode = '0;
  logic                instr_valid;
  logic                instr_ready = 1'b0;
  logic [INSTR_W-1:0]  instr_word;
  logic                instr_err;
  logic [2:0]          err_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_field_encoder_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .hdr_opcode  (hdr_opcode),
    .hdr_optype  (hdr_optype),
    .opnd_valid  (opnd_valid),
    .opnd_ready  (opnd_ready),
    .opnd_value  (opnd_value),
    .opnd_mode   (opnd_mode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .instr_err   (instr_err),
    .err_mask    (err_mask)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  ot;
    logic [15:0] v1, v2, v3;
    logic [1:0]  m1, m2, m3;
    logic [31:0] exp_word;
    logic [2:0]  exp_mask;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_hdr(input logic [4:0] opc, input logic [2:0] ot);
    int n = 0;
    @(negedge clk);
    hdr_valid = 1'b1; hdr_opcode = opc; hdr_optype = ot;
    while (!hdr_ready && n < 20) begin @(negedge clk); n++; end
    if (!hdr_ready) chk("hdr_timeout", 32'(hdr_ready), 32'd1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic send_opnd(input logic [15:0] v, input logic [1:0] m);
    int n = 0;
    @(negedge clk);
    opnd_valid = 1'b1; opnd_value = v; opnd_mode = m;
    while (!opnd_ready && n < 20) begin @(negedge clk); n++; end
    if (!opnd_ready) chk("opnd_timeout", 32'(opnd_ready), 32'd1);
    @(posedge clk); #1;
    opnd_valid = 1'b0;
  endtask

  // Called right after the third operand; also checks one-cycle latency
  task automatic wait_word(input logic [31:0] exp_word, input logic [2:0] exp_mask,
                           input logic cmp_word, output logic [31:0] got);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'd0);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    got = instr_word;
    if (cmp_word) chk("instr_word", instr_word, exp_word);
    chk("err_mask", 32'(err_mask), 32'(exp_mask));
    chk("instr_err", 32'(instr_err), 32'(|exp_mask));
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] got;
    send_hdr(v.opc, v.ot);
    send_opnd(v.v1, v.m1);
    send_opnd(v.v2, v.m2);
    send_opnd(v.v3, v.m3);
    wait_word(v.exp_word, v.exp_mask, 1'b1, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [4:0]  opc;
    logic [2:0]  ot;
    logic [15:0] val [3];
    logic [1:0]  md  [3];
    logic [7:0]  f;

    vecs[0] = '{5'h03, 3'b000, 16'hFFFF, 16'd127, 16'hFF80, 2'd0, 2'd0, 2'd0, 32'h18FF7F80, 3'b000};
    vecs[1] = '{5'h1F, 3'b111, 16'd5, 16'd63, 16'd0, 2'd1, 2'd1, 2'd1, 32'hFF457F40, 3'b000};
    vecs[2] = '{5'h00, 3'b100, 16'd64, 16'd128, 16'hFF7F, 2'd2, 2'd0, 2'd0, 32'h0480807F, 3'b111};
    vecs[3] = '{5'h15, 3'b011, 16'hFF80, 16'hFFFF, 16'd63, 2'd0, 2'd0, 2'd3, 32'hAB803FFF, 3'b010};
    vecs[4] = '{5'h01, 3'b101, 16'd0, 16'd129, 16'h7FFF, 2'd2, 2'd0, 2'd1, 32'h0D80817F, 3'b011};

    // Reset state
    #12;
    chk("rst_hdr_ready", 32'(hdr_ready), 32'd0);
    chk("rst_opnd_ready", 32'(opnd_ready), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_word", instr_word, 32'd0);
    chk("rst_instr_err", 32'(instr_err), 32'd0);
    chk("rst_err_mask", 32'(err_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Backpressure in OUT, then chained header in the releasing cycle
    send_hdr(5'h0A, 3'b010);
    send_opnd(16'd10, 2'd0);
    send_opnd(16'd20, 2'd3);
    send_opnd(16'd30, 2'd0);
    @(negedge clk);
    hdr_valid = 1'b1; hdr_opcode = 5'h11; hdr_optype = 3'b001;
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_word", instr_word, 32'h520AD41E);
      chk("bp_hdr_ready", 32'(hdr_ready), 32'd0);
      chk("bp_opnd_ready", 32'(opnd_ready), 32'd0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    #1;
    chk("chain_hdr_ready", 32'(hdr_ready), 32'd1);
    @(posedge clk); #1;
    instr_ready = 1'b0; hdr_valid = 1'b0;
    @(negedge clk);
    chk("chain_valid_low", 32'(instr_valid), 32'd0);
    chk("chain_in_op1", 32'(opnd_ready), 32'd1);
    send_opnd(16'hFFFB, 2'd0);
    send_opnd(16'd100, 2'd0);
    send_opnd(16'd33, 2'd2);
    wait_word(32'h89FB64A1, 3'b000, 1'b1, got);

    // Reset mid-transfer in OP2
    send_hdr(5'h07, 3'b111);
    send_opnd(16'd9, 2'd1);
    @(negedge clk);
    chk("pre_rst_op2", 32'(opnd_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_hdr_ready", 32'(hdr_ready), 32'd0);
    chk("mrst_opnd_ready", 32'(opnd_ready), 32'd0);
    chk("mrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("mrst_instr_word", instr_word, 32'd0);
    chk("mrst_instr_err", 32'(instr_err), 32'd0);
    chk("mrst_err_mask", 32'(err_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_hdr(5'h02, 3'b000);
    send_opnd(16'd1, 2'd0);
    send_opnd(16'd2, 2'd0);
    send_opnd(16'd3, 2'd0);
    wait_word(32'h10010203, 3'b000, 1'b1, got);

    // Round trip through a sign-extend decoder
    for (int i = 0; i < 8; i++) begin
      opc = 5'($urandom_range(0, 31));
      ot  = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        md[k] = 2'($urandom_range(0, 3));
        if (ot[2-k]) val[k] = 16'($urandom_range(0, 63));
        else         val[k] = 16'($urandom_range(0, 255)) - 16'd128;
      end
      send_hdr(opc, ot);
      for (int k = 0; k < 3; k++) send_opnd(val[k], md[k]);
      wait_word(32'd0, 3'b000, 1'b0, got);
      chk("rt_header", 32'(got[31:24]), 32'({opc, ot}));
      for (int k = 0; k < 3; k++) begin
        f = got[23 - 8*k -: 8];
        if (ot[2-k]) chk("rt_reg", 32'(f), 32'({md[k], val[k][5:0]}));
        else         chk("rt_imm", 32'({{8{f[7]}}, f}), 32'(val[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
